// File: rtl/icache_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MEM_WAIT,
    FILL
  } icache_state_t;

  localparam int unsigned LINE_BYTES   = 16;
  localparam int unsigned OFFSET_W     = 4;
  localparam int unsigned WORD_SEL_LSB = 2;

  localparam logic [31:0] INSTR_NONE = 32'h0000_0000;

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage: combinational read, synchronous write and clear-all.
module icache_array #(
  parameter int unsigned NUM_LINES = 16,
  parameter int unsigned IDX_W     = $clog2(NUM_LINES),
  parameter int unsigned TAG_W     = 32 - 4 - IDX_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic             rd_valid_o,
  output logic [TAG_W-1:0] rd_tag_o,
  output logic [127:0]     rd_data_o,
  input  logic             we_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [TAG_W-1:0] wr_tag_i,
  input  logic [127:0]     wr_data_i,
  input  logic             wr_valid_i
);

  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [127:0]         data_q [NUM_LINES];

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i];

  // A write in the same cycle as a clear still lands, with its own valid bit.
  always_comb begin
    valid_d = valid_q;
    if (clear_i) valid_d = '0;
    if (we_i) valid_d[wr_idx_i] = wr_valid_i;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Tags and data carry no reset; they are meaningless until their valid bit is set.
  always_ff @(posedge clock) begin
    if (we_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache with single-line fill from memory.
module icache_dm
  import icache_pkg::*;
#(
  parameter int unsigned NUM_LINES  = 16,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned IDX_W      = $clog2(NUM_LINES),
  parameter int unsigned TAG_W      = 32 - OFFSET_W - IDX_W
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [31:0]              phys_addr_in,
  input  logic                     addr_valid,
  input  logic                     flush,
  output logic [31:0]              instr_out,
  output logic                     instr_valid,
  output logic                     iCache_stall,
  output logic                     mem_req,
  output logic [31:0]              mem_addr,
  input  logic                     mem_rvalid,
  input  logic [LINE_WORDS*32-1:0] mem_rdata
);

  localparam int unsigned LINE_NUM_W = 32 - OFFSET_W;

  icache_state_t state_q, state_d;
  logic [LINE_NUM_W-1:0] miss_q, miss_d;
  logic                  drop_q, drop_d;

  logic [TAG_W-1:0]             addr_tag;
  logic [IDX_W-1:0]             addr_idx;
  logic [1:0]                   word_sel;
  logic                         rd_valid;
  logic [TAG_W-1:0]             rd_tag;
  logic [127:0]                 rd_data;
  logic [LINE_WORDS-1:0][31:0]  line_words;
  logic                         hit;
  logic                         arr_we;
  logic                         wr_valid;
  logic                         unused_byte_sel;

  assign addr_tag        = phys_addr_in[31:IDX_W+OFFSET_W];
  assign addr_idx        = phys_addr_in[IDX_W+OFFSET_W-1:OFFSET_W];
  assign word_sel        = phys_addr_in[OFFSET_W-1:WORD_SEL_LSB];
  assign unused_byte_sel = ^phys_addr_in[WORD_SEL_LSB-1:0];
  assign line_words      = rd_data;

  assign hit = addr_valid & rd_valid & (rd_tag == addr_tag);

  // A flush anywhere during the wait, including the return cycle, voids the incoming line.
  assign wr_valid = ~(drop_q | flush);

  icache_array #(
    .NUM_LINES(NUM_LINES),
    .IDX_W    (IDX_W),
    .TAG_W    (TAG_W)
  ) u_array (
    .clock     (clock),
    .reset     (reset),
    .clear_i   (flush),
    .rd_idx_i  (addr_idx),
    .rd_valid_o(rd_valid),
    .rd_tag_o  (rd_tag),
    .rd_data_o (rd_data),
    .we_i      (arr_we),
    .wr_idx_i  (miss_q[IDX_W-1:0]),
    .wr_tag_i  (miss_q[LINE_NUM_W-1:IDX_W]),
    .wr_data_i (mem_rdata),
    .wr_valid_i(wr_valid)
  );

  always_comb begin
    state_d      = state_q;
    miss_d       = miss_q;
    drop_d       = drop_q;
    instr_valid  = 1'b0;
    instr_out    = INSTR_NONE;
    iCache_stall = 1'b0;
    mem_req      = 1'b0;
    mem_addr     = '0;
    arr_we       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (addr_valid) begin
          if (hit) begin
            instr_valid = 1'b1;
            instr_out   = line_words[word_sel];
          end else begin
            iCache_stall = 1'b1;
            miss_d       = phys_addr_in[31:OFFSET_W];
            state_d      = MEM_WAIT;
          end
        end
      end
      MEM_WAIT: begin
        iCache_stall = 1'b1;
        mem_req      = 1'b1;
        mem_addr     = {miss_q, {OFFSET_W{1'b0}}};
        if (flush) drop_d = 1'b1;
        if (mem_rvalid) begin
          arr_we  = 1'b1;
          state_d = FILL;
        end
      end
      FILL: begin
        iCache_stall = 1'b1;
        drop_d       = 1'b0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      miss_q  <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      miss_q  <= miss_d;
      drop_q  <= drop_d;
    end
  end

endmodule

// File: tb/tb_icache_dm.sv
// Self-checking bench for icache_dm: directed scenarios followed by random traffic.
module tb_icache_dm;

  logic         clock;
  logic         reset;
  logic [31:0]  phys_addr_in;
  logic         addr_valid;
  logic         flush;
  logic [31:0]  instr_out;
  logic         instr_valid;
  logic         iCache_stall;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_rvalid;
  logic [127:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  icache_dm #(
    .NUM_LINES (16),
    .LINE_WORDS(4)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .phys_addr_in(phys_addr_in),
    .addr_valid  (addr_valid),
    .flush       (flush),
    .instr_out   (instr_out),
    .instr_valid (instr_valid),
    .iCache_stall(iCache_stall),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each slot remembers which 16-byte line (addr[31:4]) it holds.
  bit           m_valid [16];
  logic [27:0]  m_line  [16];
  logic [127:0] m_data  [16];
  int           m_phase = 0;  // 0 lookup, 1 waiting for memory, 2 fill
  logic [27:0]  m_miss  = '0;
  bit           m_drop  = 0;

  function automatic bit m_hit(input logic [31:0] a);
    return m_valid[a[7:4]] && (m_line[a[7:4]] == a[31:4]);
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      m_phase = 0;
      m_drop  = 0;
      foreach (m_valid[i]) m_valid[i] = 0;
    end else begin
      case (m_phase)
        0: begin
          bit miss_now;
          miss_now = addr_valid && !m_hit(phys_addr_in);
          if (flush) foreach (m_valid[i]) m_valid[i] = 0;
          if (miss_now) begin
            m_miss  = phys_addr_in[31:4];
            m_phase = 1;
          end
        end
        1: begin
          bit drop_now;
          drop_now = m_drop || flush;
          if (flush) begin
            foreach (m_valid[i]) m_valid[i] = 0;
            m_drop = 1;
          end
          if (mem_rvalid) begin
            m_line[m_miss[3:0]]  = m_miss;
            m_data[m_miss[3:0]]  = mem_rdata;
            m_valid[m_miss[3:0]] = !drop_now;
            m_phase = 2;
          end
        end
        default: begin
          if (flush) foreach (m_valid[i]) m_valid[i] = 0;
          m_drop  = 0;
          m_phase = 0;
        end
      endcase
    end
  end

  // Every cycle: derive the required outputs from the model and compare.
  always @(negedge clock) begin
    logic [31:0] e_instr, e_maddr;
    logic        e_valid, e_stall, e_req;
    logic [127:0] ln;
    e_instr = 32'h0; e_maddr = 32'h0; e_valid = 0; e_stall = 0; e_req = 0;
    case (m_phase)
      0: begin
        if (addr_valid) begin
          if (m_hit(phys_addr_in)) begin
            ln      = m_data[phys_addr_in[7:4]];
            e_valid = 1;
            e_instr = ln[32*phys_addr_in[3:2] +: 32];
          end else begin
            e_stall = 1;
          end
        end
      end
      1: begin
        e_stall = 1;
        e_req   = 1;
        e_maddr = {m_miss, 4'h0};
      end
      default: e_stall = 1;
    endcase
    chk("instr_out", instr_out, e_instr);
    chk("instr_valid", {31'h0, instr_valid}, {31'h0, e_valid});
    chk("stall", {31'h0, iCache_stall}, {31'h0, e_stall});
    chk("mem_req", {31'h0, mem_req}, {31'h0, e_req});
    chk("mem_addr", mem_addr, e_maddr);
  end

  task automatic step(input logic rs, input logic av, input logic [31:0] a, input logic fl,
                      input logic rv, input logic [127:0] rd);
    @(posedge clock);
    #1;
    reset        = rs;
    addr_valid   = av;
    phys_addr_in = a;
    flush        = fl;
    mem_rvalid   = rv;
    mem_rdata    = rd;
    @(negedge clock);
  endtask

  localparam logic [127:0] LINE_A = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] LINE_B = 128'hBBBB0003_BBBB0002_BBBB0001_BBBB0000;

  initial begin
    reset = 1; addr_valid = 0; phys_addr_in = 0; flush = 0; mem_rvalid = 0; mem_rdata = 0;
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("reset_stall", {31'h0, iCache_stall}, 32'h0);
    chk("reset_mem_req", {31'h0, mem_req}, 32'h0);

    // Cold miss, memory answers three cycles after the miss.
    step(0, 1, 32'h0000_1004, 0, 0, 0);
    chk("cold_miss_stall", {31'h0, iCache_stall}, 32'h1);
    step(0, 1, 32'h0000_1004, 0, 0, 0);
    chk("cold_req", {31'h0, mem_req}, 32'h1);
    chk("cold_addr", mem_addr, 32'h0000_1000);
    step(0, 1, 32'h0000_1004, 0, 0, 0);
    step(0, 1, 32'h0000_1004, 0, 1, LINE_A);
    step(0, 1, 32'h0000_1004, 0, 0, 0);
    chk("fill_stall", {31'h0, iCache_stall}, 32'h1);
    chk("fill_req", {31'h0, mem_req}, 32'h0);
    step(0, 1, 32'h0000_1004, 0, 0, 0);
    chk("hit_word1", instr_out, 32'h2222_2222);
    chk("hit_valid", {31'h0, instr_valid}, 32'h1);
    chk("hit_stall", {31'h0, iCache_stall}, 32'h0);
    step(0, 1, 32'h0000_100C, 0, 0, 0);
    chk("hit_word3", instr_out, 32'h4444_4444);
    chk("hit_no_req", {31'h0, mem_req}, 32'h0);

    // Conflict on index 0.
    step(0, 1, 32'h0000_2000, 0, 0, 0);
    chk("conflict_stall", {31'h0, iCache_stall}, 32'h1);
    step(0, 1, 32'h0000_2000, 0, 0, 0);
    chk("conflict_addr", mem_addr, 32'h0000_2000);
    step(0, 1, 32'h0000_2000, 0, 1, LINE_B);
    step(0, 1, 32'h0000_2000, 0, 0, 0);
    step(0, 1, 32'h0000_1000, 0, 0, 0);
    chk("evicted_miss", {31'h0, iCache_stall}, 32'h1);
    step(0, 0, 0, 0, 1, LINE_A);
    step(0, 0, 0, 0, 0, 0);

    // Line in another slot, to be invalidated by the later flush.
    step(0, 1, 32'h0000_5020, 0, 0, 0);
    step(0, 0, 0, 0, 1, LINE_B);
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 32'h0000_5024, 0, 0, 0);
    chk("slot2_hit", instr_out, 32'hBBBB_0001);

    // Flush during the wait: handshake completes but the line stays invalid.
    step(0, 1, 32'h0000_3000, 0, 0, 0);
    step(0, 1, 32'h0000_3000, 1, 0, 0);
    step(0, 1, 32'h0000_3000, 0, 1, LINE_A);
    step(0, 1, 32'h0000_3000, 0, 0, 0);
    step(0, 1, 32'h0000_3000, 0, 0, 0);
    chk("dropped_miss", {31'h0, iCache_stall}, 32'h1);
    step(0, 0, 0, 0, 1, LINE_A);
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 32'h0000_5020, 0, 0, 0);
    chk("flushed_miss", {31'h0, iCache_stall}, 32'h1);
    step(0, 0, 0, 0, 1, LINE_B);
    step(0, 0, 0, 0, 0, 0);

    // Reset mid-wait, late memory response must be ignored.
    step(0, 1, 32'h0000_4010, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("pre_reset_req", {31'h0, mem_req}, 32'h1);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, LINE_A);
    chk("post_reset_req", {31'h0, mem_req}, 32'h0);
    chk("post_reset_stall", {31'h0, iCache_stall}, 32'h0);
    step(0, 1, 32'h0000_4010, 0, 0, 0);
    chk("post_reset_miss", {31'h0, iCache_stall}, 32'h1);
    step(0, 0, 0, 0, 1, LINE_A);
    step(0, 0, 0, 0, 0, 0);

    // Stray response while idle.
    step(0, 0, 0, 0, 1, LINE_B);
    chk("stray_stall", {31'h0, iCache_stall}, 32'h0);
    chk("stray_valid", {31'h0, instr_valid}, 32'h0);
    step(0, 0, 0, 0, 0, 0);
    chk("stray_no_req", {31'h0, mem_req}, 32'h0);

    for (int n = 0; n < 3000; n++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 2) << 8) | ($urandom_range(0, 15) << 4) | $urandom_range(0, 15);
      step(($urandom % 64) == 0, ($urandom % 4) != 0, a, ($urandom % 16) == 0,
           ($urandom % 3) == 0, {$urandom, $urandom, $urandom, $urandom});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/icache_dm.md
Name: icache_dm

Overview:
- Direct-mapped instruction cache directly downstream of the instruction TLB.
- Consumes the translated physical fetch address and a valid qualifier (the TLB's not-stall), and returns a 32-bit instruction word.
- On a miss it fetches a 128-bit line from the instruction memory port and asserts stall to the fetch stage until the line is filled.

Parameters:
- NUM_LINES, 16, number of cache lines; power of two, at least 2.
- LINE_WORDS, 4, 32-bit words per line; fixed at 4, so the line is 128 bits / 16 bytes.
- IDX_W, $clog2(NUM_LINES), index width (derived).
- TAG_W, 32-4-IDX_W, tag width (derived; 24 at defaults).

Ports:
- clock  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- phys_addr_in  in  32  physical fetch address from the TLB.
- addr_valid  in  1  phys_addr_in is meaningful this cycle (TLB not stalling).
- flush  in  1  one-cycle pulse; invalidates every line.
- instr_out  out  32  fetched instruction; 32'h0000_0000 when instr_valid=0.
- instr_valid  out  1  instr_out is valid this cycle.
- iCache_stall  out  1  fetch must hold its PC.
- mem_req  out  1  line-fill request, held high until mem_rvalid.
- mem_addr  out  32  line-aligned fill address; bits [3:0] always 0.
- mem_rvalid  in  1  one-cycle pulse; mem_rdata holds the line.
- mem_rdata  in  128  fill line; word k = bits [32k+31:32k].

Behaviour:
- Address split:
  - offset [3:0]; bits [1:0] are ignored.
  - word select [3:2].
  - index [IDX_W+3:4].
  - tag [31:IDX_W+4].
- Storage: per line a valid bit, a TAG_W tag and 128 data bits. Reset clears all valid bits only; data and tags are don't-care after reset.
- Reset values: state=IDLE, instr_valid=0, instr_out=0, iCache_stall=0, mem_req=0, mem_addr=0. Reset has priority over all other inputs, including mid-fill. A mem_rvalid arriving after reset is ignored.
- FSM states: IDLE, MEM_WAIT, FILL.
- IDLE:
  - Hit is combinational: addr_valid & valid[idx] & (tag[idx]==addr tag).
  - On a hit: instr_valid=1, instr_out=selected word, stall=0, all in the same cycle.
  - On addr_valid with a miss: stall=1 combinationally. Latch {addr[31:4],4'b0} into the miss register and go to MEM_WAIT.
  - addr_valid=0: no lookup, stall=0, instr_valid=0.
- MEM_WAIT:
  - mem_req=1 and mem_addr=miss register; stall=1.
  - phys_addr_in changes are ignored.
  - On mem_rvalid: write data and tag at the latched index, set valid, go to FILL. mem_req drops in the FILL cycle.
- FILL: stall=1, no lookup, next state IDLE. The lookup after a fill re-evaluates the current phys_addr_in; if that address differs from the filled line it may miss again.
- Miss timing: miss detected in cycle T, mem_rvalid in cycle T+k (k≥1), FILL in T+k+1, hit in T+k+2.
- flush:
  - In IDLE or FILL: clears all valid bits at the clock edge. A lookup in the same cycle uses the pre-flush contents.
  - In MEM_WAIT: clears valid bits and sets a drop flag. The pending fill still completes the handshake, but its line is written with valid=0. The drop flag is cleared on leaving FILL.
- mem_rvalid while in IDLE or FILL: ignored.
- Replacement: direct-mapped overwrite, no write-back (read-only cache).

Decomposition:
- Package icache_pkg holds:
  - state enum icache_state_t {IDLE, MEM_WAIT, FILL}.
  - constants LINE_BYTES=16, OFFSET_W=4, WORD_SEL_LSB=2.
  - the DEAD/zero fill constant used for instr_out when invalid.
- Sub-module icache_array: valid/tag/data storage with a combinational read port, a synchronous write port, a synchronous clear-all (reset/flush), and a valid-on-write input. The top level keeps the FSM, miss register and drop flag.

Test Plan:
- Reset then addr 0x0000_1004 valid → stall=1 in the same cycle; next cycle mem_req=1, mem_addr=0x0000_1000. Memory returns 0x44444444_33333333_22222222_11111111 after 3 cycles → FILL, then instr_out=0x22222222, instr_valid=1, stall=0.
- After that fill, addr 0x0000_100C → hit in the same cycle with instr_out=0x44444444, no mem_req.
- Conflict: 0x0000_1000 then 0x0000_2000 (same index 0, different tag) → miss with mem_addr=0x0000_2000. A subsequent 0x0000_1000 misses again.
- flush pulse during MEM_WAIT for 0x0000_3000 → handshake completes, returning to IDLE. A lookup of 0x0000_3000 misses again. Earlier-filled lines also miss.
- reset asserted mid-MEM_WAIT, then mem_rvalid one cycle later → mem_req=0 after the reset edge, no line becomes valid, stall=0 in IDLE with addr_valid=0.
- addr_valid=0 with a stray mem_rvalid pulse → no state change, instr_valid=0, stall=0.
